cayde_lsu: RTL

CAYDE_LSU -- requirements
Module: cayde_lsu

---
 rtl/cayde_lsu.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cayde_lsu.sv
// Load/store unit: one outstanding aligned access, byte-lane steering and load extension.
// Define CAYDE_SIGNED_LOAD_EN to honour req_signed_i on loads; otherwise loads zero-extend.
module cayde_lsu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic              mem_err_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

`ifdef CAYDE_SIGNED_LOAD_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e           state_q;
    logic             store_q;
    logic             signed_q;
    logic [1:0]       size_q;
    logic [OFF_W-1:0] off_q;

    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  align_mask;
    logic              req_legal;
    logic [NB-1:0]     be_mask;
    logic [NB-1:0]     req_be;
    logic [XLEN-1:0]   req_wdata_sh;
    logic [ADDR_W-1:0] req_addr_al;

    always_comb begin
        req_off    = req_addr_i[OFF_W-1:0];
        align_mask = OFF_W'((32'd1 << req_size_i) - 32'd1);
        req_legal  = ((req_off & align_mask) == '0) && !(req_size_i == 2'd3 && XLEN != 64);
        for (int unsigned i = 0; i < NB; i++) begin
            be_mask[i] = (i < (32'd1 << req_size_i));
        end
        req_be       = be_mask << req_off;
        req_wdata_sh = req_wdata_i << {req_off, 3'b000};
        req_addr_al  = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    logic [XLEN-1:0] load_sh;
    logic [XLEN-1:0] field_mask;
    logic [XLEN-1:0] load_data;
    logic            field_msb;

    // Full-width loads keep an all-ones mask, so the extension term vanishes.
    always_comb begin
        load_sh    = mem_rdata_i >> {off_q, 3'b000};
        field_mask = '1;
        field_msb  = 1'b0;
        case (size_q)
            2'd0: begin
                field_mask = XLEN'(8'hff);
                field_msb  = load_sh[7];
            end
            2'd1: begin
                field_mask = XLEN'(16'hffff);
                field_msb  = load_sh[15];
            end
            2'd2: begin
                field_mask = XLEN'(32'hffff_ffff);
                field_msb  = load_sh[31];
            end
            default: begin
            end
        endcase
        load_data = load_sh & field_mask;
        if (SIGNED_EN && signed_q && field_msb) begin
            load_data = load_data | ~field_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            store_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= '0;
            req_ready_o  <= 1'b1;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        store_q     <= req_store_i;
                        signed_q    <= req_signed_i;
                        size_q      <= req_size_i;
                        off_q       <= req_off;
                        if (req_legal) begin
                            state_q     <= StReq;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_store_i;
                            mem_be_o    <= req_be;
                            mem_addr_o  <= req_addr_al;
                            mem_wdata_o <= req_wdata_sh;
                        end else begin
                            // Illegal access completes without touching memory.
                            state_q      <= StDone;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        state_q      <= StDone;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= mem_err_i;
                        resp_rdata_o <= (store_q || mem_err_i) ? '0 : load_data;
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    req_ready_o  <= 1'b1;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
